// File: rtl/switch_debounce.sv
// switch_debounce: two-flop synchroniser, prescaled sampler and per-bit
// DEPTH-sample agreement filter for the raw board DIP switches. Produces the
// debounced switch_i bus for the switch MMIO reader, a one-cycle change
// strobe and a ready flag raised once the history window has filled.
module switch_debounce #(
    parameter int WIDTH    = 19,
    parameter int TICK_DIV = 100000,
    parameter int DEPTH    = 4
) (
    input  logic             switclk,
    input  logic             switrst_n,
    input  logic [WIDTH-1:0] switch_raw,
    output logic [WIDTH-1:0] switch_i,
    output logic             switch_chg,
    output logic             switch_ready
);

    // Prescaler width; a one-cycle divider still needs a 1-bit counter.
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(TICK_DIV - 1);

    // Sample counter only has to reach DEPTH and then saturates.
    localparam int SW = $clog2(DEPTH + 1);
    localparam logic [SW-1:0] READY_AT = SW'(DEPTH - 1);
    localparam logic [SW-1:0] SAT_AT   = SW'(DEPTH);

    logic [WIDTH-1:0]            sync1;
    logic [WIDTH-1:0]            sync2;
    logic [CW-1:0]               count;
    logic                        tick;
    logic [SW-1:0]               samples;
    logic [WIDTH-1:0][DEPTH-2:0] hist;
    logic [WIDTH-1:0][DEPTH-2:0] hist_next;
    logic [WIDTH-1:0]            value_next;
    logic [DEPTH-1:0]            win;

    assign tick = (count == LAST_COUNT);

    // Two-flop synchroniser bringing the asynchronous switches into the clock domain.
    always_ff @(posedge switclk) begin
        if (!switrst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= switch_raw;
            sync2 <= sync1;
        end
    end

    // Free-running prescaler, 0..TICK_DIV-1, restarting from 0 on reset.
    always_ff @(posedge switclk) begin
        if (!switrst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // Per-bit window: shift the new sample into the history and accept a new
    // level only when every sample in the window agrees.
    always_comb begin
        hist_next  = hist;
        value_next = switch_i;
        win        = '0;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            win           = {hist[b], sync2[b]};
            hist_next[b]  = win[DEPTH-2:0];
            if (&win) begin
                value_next[b] = 1'b1;
            end else if (~|win) begin
                value_next[b] = 1'b0;
            end
        end
    end

    // History, debounced value and change strobe advance only on tick edges;
    // the strobe is cleared on every other edge so it lasts one cycle.
    always_ff @(posedge switclk) begin
        if (!switrst_n) begin
            hist       <= '0;
            switch_i   <= '0;
            switch_chg <= 1'b0;
        end else if (tick) begin
            hist       <= hist_next;
            switch_i   <= value_next;
            switch_chg <= (value_next != switch_i);
        end else begin
            switch_chg <= 1'b0;
        end
    end

    // Saturating sample counter; ready rises on the edge of the DEPTH-th tick,
    // the first edge at which the window holds only post-reset samples.
    always_ff @(posedge switclk) begin
        if (!switrst_n) begin
            samples      <= '0;
            switch_ready <= 1'b0;
        end else if (tick) begin
            if (samples != SAT_AT) begin
                samples <= samples + SW'(1);
            end
            if (samples == READY_AT) begin
                switch_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with TICK_DIV=4, DEPTH=3. Edge numbers in
// comments count posedges after the most recent reset release; ticks fall on
// every multiple of 4. Inputs change and outputs are sampled on negedges.
module tb_switch_debounce;

    localparam int WIDTH    = 19;
    localparam int TICK_DIV = 4;
    localparam int DEPTH    = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] sw_i;
    logic             chg;
    logic             ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    switch_debounce #(
        .WIDTH   (WIDTH),
        .TICK_DIV(TICK_DIV),
        .DEPTH   (DEPTH)
    ) dut (
        .switclk     (clk),
        .switrst_n   (rst_n),
        .switch_raw  (raw),
        .switch_i    (sw_i),
        .switch_chg  (chg),
        .switch_ready(ready)
    );

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [WIDTH-1:0] ei, input logic ec, input logic er);
        check({tag, "_i"}, sw_i, ei);
        check({tag, "_chg"}, WIDTH'(chg), WIDTH'(ec));
        check({tag, "_rdy"}, WIDTH'(ready), WIDTH'(er));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance n cycles expecting a steady output and no change strobe.
    task automatic hold(input string tag, input int n, input logic [WIDTH-1:0] ei);
        for (int k = 0; k < n; k++) begin
            cyc(1);
            check({tag, "_i"}, sw_i, ei);
            check({tag, "_chg"}, WIDTH'(chg), '0);
        end
    endtask

    initial begin
        // 1. Reset with all switches high, then the first window fills.
        rst_n = 1'b0;
        raw   = 19'h7FFFF;
        cyc(3);
        check_all("reset", 19'h00000, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc(11);                                   // edge 11
        check_all("pre_ready", 19'h00000, 1'b0, 1'b0);
        cyc(1);                                    // edge 12: third tick
        check_all("ready_edge", 19'h7FFFF, 1'b1, 1'b1);
        cyc(1);                                    // edge 13
        check_all("ready_after", 19'h7FFFF, 1'b0, 1'b1);

        // 2. Settle to zero (ticks 16, 20, 24), then a 5-cycle glitch on bit0.
        raw = 19'h00000;
        hold("settle_hi", 10, 19'h7FFFF);          // edges 14..23
        cyc(1);                                    // edge 24
        check_all("settle_zero", 19'h00000, 1'b1, 1'b1);
        cyc(1);                                    // edge 25
        check_all("settle_after", 19'h00000, 1'b0, 1'b1);
        raw = 19'h00001;
        hold("glitch_on", 5, 19'h00000);           // edges 26..30
        raw = 19'h00000;
        hold("glitch_off", 10, 19'h00000);         // edges 31..40

        // 3. Stable change to 0x00005: seen at ticks 44, 48, accepted at 52.
        raw = 19'h00005;
        for (int e = 41; e <= 60; e++) begin
            cyc(1);
            check("stable_i", sw_i, (e >= 52) ? 19'h00005 : 19'h00000);
            check("stable_chg", WIDTH'(chg), WIDTH'(e == 52));
        end

        // 4. Bit3 toggled right after each tick, so samples alternate.
        hold("chatter_pre", 4, 19'h00005);         // edges 61..64
        for (int t = 0; t < 10; t++) begin
            raw[3] = ~raw[3];
            hold("chatter", 4, 19'h00005);         // ends at edge 104
        end

        // 5. Two agreeing ticks (108, 112) for 0x00010, then reset mid-window.
        raw = 19'h00010;
        hold("partial", 8, 19'h00005);             // edges 105..112
        rst_n = 1'b0;
        cyc(1);
        check_all("mid_reset", 19'h00000, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc(11);                                   // edge 11 after release
        check_all("mid_pre", 19'h00000, 1'b0, 1'b0);
        cyc(1);                                    // edge 12
        check_all("mid_ready", 19'h00010, 1'b1, 1'b1);
        cyc(1);                                    // edge 13
        check_all("mid_after", 19'h00010, 1'b0, 1'b1);

        // 6. Bits 0, 7 and 18 rise together; accepted together at tick 24.
        raw = 19'h40091;
        for (int e = 14; e <= 30; e++) begin
            cyc(1);
            check("simul_i", sw_i, (e >= 24) ? 19'h40091 : 19'h00010);
            check("simul_chg", WIDTH'(chg), WIDTH'(e == 24));
            check("simul_rdy", WIDTH'(ready), WIDTH'(1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
